// File: rtl/sgm_stream_argsel_if.sv
// Cost-stream handshake bundle for sgm_stream_argsel: beat input plus result output.
// Carries out_uniq only when SGM_ARGSEL_UNIQ_EN is defined.
interface sgm_stream_argsel_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int IDX_W  = 10
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W*LANES-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_idx;
`ifdef SGM_ARGSEL_UNIQ_EN
  logic                      out_uniq;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_uniq
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_uniq
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
`endif
endinterface

// File: rtl/sgm_stream_argsel.sv
// Streaming arg-max/arg-min over ARR_L costs delivered LANES per beat; ties keep the lower index.
// Optional SGM_ARGSEL_UNIQ_EN adds second-best tracking and the out_uniq flag.
module sgm_stream_argsel #(
  parameter int DATA_W     = 8,
  parameter int ARR_L      = 64,
  parameter int LANES      = 4,
  parameter int MODE       = 0,
  parameter int IDX_OFFSET = 0,
  parameter int IDX_W      = 10
`ifdef SGM_ARGSEL_UNIQ_EN
  ,
  parameter int UNIQ_PCT   = 10
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  sgm_stream_argsel_if.slave   strm
);

  localparam int BEATS  = ARR_L / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [DATA_W-1:0] WORST = (MODE == 0) ? {DATA_W{1'b0}} : {DATA_W{1'b1}};

  // Strict comparison: a displaces b only when strictly better, so earlier indices win ties.
  function automatic logic isBetter(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (MODE == 0) ? (a > b) : (a < b);
  endfunction

`ifdef SGM_ARGSEL_UNIQ_EN
  localparam int PW = DATA_W + 8;

  function automatic logic uniqFlag(input logic [DATA_W-1:0] best, input logic [DATA_W-1:0] sec);
    logic [PW-1:0] lhs;
    logic [PW-1:0] rhs;
    if (MODE == 0) begin
      lhs = PW'(best) * PW'(100);
      rhs = PW'(sec)  * PW'(100 + UNIQ_PCT);
    end else begin
      lhs = PW'(sec)  * PW'(100);
      rhs = PW'(best) * PW'(100 + UNIQ_PCT);
    end
    return lhs > rhs;
  endfunction
`endif

  logic [BEAT_W-1:0] beatCnt_p0;
  logic [DATA_W-1:0] accBest_p0;
  logic [IDX_W-1:0]  accIdx_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] resData_p1;
  logic [IDX_W-1:0]  resIdx_p1;

  logic [DATA_W-1:0] foldBest;
  logic [IDX_W-1:0]  foldIdx;
  logic              foldHave;
  logic [IDX_W-1:0]  beatBase;
  logic [IDX_W-1:0]  laneIdx;
  logic [DATA_W-1:0] laneVal;
`ifdef SGM_ARGSEL_UNIQ_EN
  logic [DATA_W-1:0] accSec_p0;
  logic [DATA_W-1:0] foldSec;
  logic              resUniq_p1;
`endif

  logic inReady;
  logic accept;
  logic lastBeat;
  logic consume;

  assign inReady  = !vld_p1 || strm.out_ready;
  assign accept   = en && strm.in_valid && inReady && !clr;
  assign lastBeat = (beatCnt_p0 == LAST_BEAT);
  assign consume  = en && vld_p1 && strm.out_ready;

  // Stage p0: fold the current beat's lanes into the running winner (empty on beat 0).
  always_comb begin
    beatBase = IDX_W'(IDX_OFFSET) + IDX_W'(beatCnt_p0) * IDX_W'(LANES);
    foldHave = (beatCnt_p0 != '0);
    foldBest = accBest_p0;
    foldIdx  = accIdx_p0;
    laneVal  = '0;
    laneIdx  = '0;
`ifdef SGM_ARGSEL_UNIQ_EN
    foldSec  = accSec_p0;
`endif
    for (int k = 0; k < LANES; k++) begin
      laneVal = strm.in_data[k*DATA_W +: DATA_W];
      laneIdx = beatBase + IDX_W'(k);
      if (!foldHave || isBetter(laneVal, foldBest)) begin
`ifdef SGM_ARGSEL_UNIQ_EN
        foldSec = foldHave ? foldBest : WORST;
`endif
        foldBest = laneVal;
        foldIdx  = laneIdx;
        foldHave = 1'b1;
      end
`ifdef SGM_ARGSEL_UNIQ_EN
      else if (!isBetter(foldSec, laneVal)) begin
        foldSec = laneVal;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !lastBeat) begin
      accBest_p0 <= foldBest;
      accIdx_p0  <= foldIdx;
`ifdef SGM_ARGSEL_UNIQ_EN
      accSec_p0  <= foldSec;
`endif
    end
  end

  // Stage p1: result register, written on the final beat and held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beatCnt_p0  <= '0;
      vld_p1      <= 1'b0;
      resData_p1  <= '0;
      resIdx_p1   <= '0;
`ifdef SGM_ARGSEL_UNIQ_EN
      resUniq_p1  <= 1'b0;
`endif
    end else if (en) begin
      if (clr) begin
        beatCnt_p0 <= '0;
      end else if (accept) begin
        beatCnt_p0 <= lastBeat ? '0 : beatCnt_p0 + 1'b1;
      end

      if (accept && lastBeat) begin
        vld_p1     <= 1'b1;
        resData_p1 <= foldBest;
        resIdx_p1  <= foldIdx;
`ifdef SGM_ARGSEL_UNIQ_EN
        resUniq_p1 <= uniqFlag(foldBest, foldSec);
`endif
      end else if (consume) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign strm.in_ready  = inReady;
  assign strm.out_valid = vld_p1;
  assign strm.out_data  = resData_p1;
  assign strm.out_idx   = resIdx_p1;
`ifdef SGM_ARGSEL_UNIQ_EN
  assign strm.out_uniq  = resUniq_p1;
`endif

endmodule
